// File: rtl/fifo_read_ctrl.sv
// Read-side pointer, address and status logic for the async FIFO.
// Optional sticky underflow flag: define FIFO_RD_UNDERFLOW_EN.
module fifo_read_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rinc,
  input  logic [ADDR_W:0]   rq2_wptr,
  input  logic              undf_clr,
  output logic [ADDR_W-1:0] radr,
  output logic [ADDR_W:0]   rptr,
  output logic              rempty,
  output logic              raempty,
  output logic [ADDR_W:0]   rlevel,
  output logic              rundf
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_n;
  logic [PW-1:0] rgray_n;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] lvl_n;
  logic          rpop;

  assign rpop    = rinc & ~rempty;
  assign rbin_n  = rbin + {{ADDR_W{1'b0}}, rpop};
  assign rgray_n = (rbin_n >> 1) ^ rbin_n;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  assign lvl_n = wbin_s - rbin_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rlevel  <= '0;
    end else begin
      rbin    <= rbin_n;
      rptr    <= rgray_n;
      rempty  <= (rgray_n == rq2_wptr);
      raempty <= (lvl_n <= AE_TH);
      rlevel  <= lvl_n;
    end
  end

  assign radr = rbin[ADDR_W-1:0];

`ifdef FIFO_RD_UNDERFLOW_EN
  logic rundf_q;

  // A fresh underflow takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rundf_q <= 1'b0;
    end else if (rinc & rempty) begin
      rundf_q <= 1'b1;
    end else if (undf_clr) begin
      rundf_q <= 1'b0;
    end
  end

  assign rundf = rundf_q;
`else
  logic unused_undf_clr;

  assign unused_undf_clr = undf_clr;
  assign rundf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl (ADDR_W=3, AEMPTY_TH=1).
// Underflow expectations follow FIFO_RD_UNDERFLOW_EN.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic       undf_clr;
  logic [2:0] radr;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       rundf;

  int ncmp = 0;
  int nerr = 0;

`ifdef FIFO_RD_UNDERFLOW_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif

  fifo_read_ctrl #(.ADDR_W(3), .AEMPTY_TH(1)) dut (
    .clk(clk), .rst_n(rst_n), .rinc(rinc),
    .rq2_wptr(rq2_wptr), .undf_clr(undf_clr),
    .radr(radr), .rptr(rptr), .rempty(rempty),
    .raempty(raempty), .rlevel(rlevel), .rundf(rundf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rinc = 1'b1; undf_clr = 1'b0; rq2_wptr = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      tick();
      ncmp++; if (radr !== 3'd0) begin nerr++; $display("FAIL rst_radr c%0d got %0d exp 0", c, radr); end
      ncmp++; if (rptr !== 4'd0) begin nerr++; $display("FAIL rst_rptr c%0d got %b exp 0000", c, rptr); end
      ncmp++; if (rempty !== 1'b1) begin nerr++; $display("FAIL rst_rempty c%0d got %b exp 1", c, rempty); end
      ncmp++; if (raempty !== 1'b1) begin nerr++; $display("FAIL rst_raempty c%0d got %b exp 1", c, raempty); end
      ncmp++; if (rlevel !== 4'd0) begin nerr++; $display("FAIL rst_rlevel c%0d got %0d exp 0", c, rlevel); end
      ncmp++; if (rundf !== 1'b0) begin nerr++; $display("FAIL rst_rundf c%0d got %b exp 0", c, rundf); end
    end
  endtask

  task automatic test_basic_pop();
    logic [3:0] exp_lvl [3];
    logic       exp_ae  [3];
    logic       exp_em  [3];
    exp_lvl = '{4'd2, 4'd1, 4'd0};
    exp_ae  = '{1'b0, 1'b1, 1'b1};
    exp_em  = '{1'b0, 1'b0, 1'b1};
    rinc = 1'b0; rq2_wptr = 4'b0010; rst_n = 1'b1;
    tick();
    ncmp++; if (rlevel !== 4'd3) begin nerr++; $display("FAIL basic_lvl got %0d exp 3", rlevel); end
    ncmp++; if (rempty !== 1'b0) begin nerr++; $display("FAIL basic_rempty got %b exp 0", rempty); end
    ncmp++; if (raempty !== 1'b0) begin nerr++; $display("FAIL basic_raempty got %b exp 0", raempty); end
    rinc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      ncmp++; if (rlevel !== exp_lvl[k]) begin nerr++; $display("FAIL pop%0d_lvl got %0d exp %0d", k, rlevel, exp_lvl[k]); end
      ncmp++; if (raempty !== exp_ae[k]) begin nerr++; $display("FAIL pop%0d_raempty got %b exp %b", k, raempty, exp_ae[k]); end
      ncmp++; if (rempty !== exp_em[k]) begin nerr++; $display("FAIL pop%0d_rempty got %b exp %b", k, rempty, exp_em[k]); end
    end
    rinc = 1'b0;
    ncmp++; if (radr !== 3'd3) begin nerr++; $display("FAIL basic_radr got %0d exp 3", radr); end
    ncmp++; if (rptr !== 4'b0010) begin nerr++; $display("FAIL basic_rptr got %b exp 0010", rptr); end
  endtask

  task automatic test_full();
    rst_n = 1'b0; rinc = 1'b0; rq2_wptr = 4'b1100;
    tick();
    rst_n = 1'b1;
    tick();
    ncmp++; if (rlevel !== 4'd8) begin nerr++; $display("FAIL full_lvl got %0d exp 8", rlevel); end
    ncmp++; if (rempty !== 1'b0) begin nerr++; $display("FAIL full_rempty got %b exp 0", rempty); end
    rinc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ncmp++; if (rlevel !== 4'(8 - k)) begin nerr++; $display("FAIL full_pop%0d_lvl got %0d exp %0d", k, rlevel, 8 - k); end
    end
    rinc = 1'b0;
    ncmp++; if (rptr !== 4'b1100) begin nerr++; $display("FAIL full_rptr got %b exp 1100", rptr); end
    ncmp++; if (radr !== 3'd0) begin nerr++; $display("FAIL full_radr got %0d exp 0", radr); end
    ncmp++; if (rempty !== 1'b1) begin nerr++; $display("FAIL full_rempty_end got %b exp 1", rempty); end
  endtask

  task automatic test_wrap();
    rq2_wptr = 4'b1000;
    tick();
    ncmp++; if (rlevel !== 4'd7) begin nerr++; $display("FAIL wrap_pre_lvl got %0d exp 7", rlevel); end
    rinc = 1'b1;
    repeat (7) tick();
    rinc = 1'b0;
    ncmp++; if (rptr !== 4'b1000) begin nerr++; $display("FAIL wrap_rbin15_rptr got %b exp 1000", rptr); end
    ncmp++; if (radr !== 3'd7) begin nerr++; $display("FAIL wrap_rbin15_radr got %0d exp 7", radr); end
    rq2_wptr = 4'b0001;
    tick();
    ncmp++; if (rlevel !== 4'd2) begin nerr++; $display("FAIL wrap_lvl got %0d exp 2", rlevel); end
    rinc = 1'b1;
    tick();
    ncmp++; if (rptr !== 4'b0000) begin nerr++; $display("FAIL wrap_pop1_rptr got %b exp 0000", rptr); end
    tick();
    rinc = 1'b0;
    ncmp++; if (rptr !== 4'b0001) begin nerr++; $display("FAIL wrap_pop2_rptr got %b exp 0001", rptr); end
    ncmp++; if (radr !== 3'd1) begin nerr++; $display("FAIL wrap_radr got %0d exp 1", radr); end
    ncmp++; if (rempty !== 1'b1) begin nerr++; $display("FAIL wrap_rempty got %b exp 1", rempty); end
  endtask

  task automatic test_underflow();
    rinc = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      ncmp++; if (rptr !== 4'b0001) begin nerr++; $display("FAIL undf%0d_rptr got %b exp 0001", c, rptr); end
      ncmp++; if (rundf !== UF) begin nerr++; $display("FAIL undf%0d_rundf got %b exp %b", c, rundf, UF); end
    end
    rinc = 1'b0; undf_clr = 1'b1;
    tick();
    ncmp++; if (rundf !== 1'b0) begin nerr++; $display("FAIL undf_clr got %b exp 0", rundf); end
    rinc = 1'b1; undf_clr = 1'b0;
    tick();
    ncmp++; if (rundf !== UF) begin nerr++; $display("FAIL undf_reset got %b exp %b", rundf, UF); end
    undf_clr = 1'b1;
    tick();
    ncmp++; if (rundf !== UF) begin nerr++; $display("FAIL undf_prio got %b exp %b", rundf, UF); end
    rinc = 1'b0; undf_clr = 1'b0;
    ncmp++; if (rptr !== 4'b0001) begin nerr++; $display("FAIL undf_end_rptr got %b exp 0001", rptr); end
  endtask

  task automatic test_simul();
    rst_n = 1'b0; rinc = 1'b0; rq2_wptr = 4'b0011;
    tick();
    rst_n = 1'b1;
    tick();
    ncmp++; if (rlevel !== 4'd2) begin nerr++; $display("FAIL simul_pre_lvl got %0d exp 2", rlevel); end
    rinc = 1'b1; rq2_wptr = 4'b0010;
    tick();
    ncmp++; if (rlevel !== 4'd2) begin nerr++; $display("FAIL simul_lvl got %0d exp 2", rlevel); end
    ncmp++; if (radr !== 3'd1) begin nerr++; $display("FAIL simul_radr got %0d exp 1", radr); end
    ncmp++; if (rptr !== 4'b0001) begin nerr++; $display("FAIL simul_rptr got %b exp 0001", rptr); end
    ncmp++; if (raempty !== 1'b0) begin nerr++; $display("FAIL simul_raempty got %b exp 0", raempty); end
    // Mid-operation reset with a pending pop must still clear everything.
    rst_n = 1'b0;
    tick();
    ncmp++; if (rptr !== 4'd0) begin nerr++; $display("FAIL midrst_rptr got %b exp 0000", rptr); end
    ncmp++; if (rlevel !== 4'd0) begin nerr++; $display("FAIL midrst_lvl got %0d exp 0", rlevel); end
    ncmp++; if (rempty !== 1'b1) begin nerr++; $display("FAIL midrst_rempty got %b exp 1", rempty); end
    rinc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rinc = 1'b0; undf_clr = 1'b0; rq2_wptr = '0;
    #2;
    test_reset();
    test_basic_pop();
    test_full();
    test_wrap();
    test_underflow();
    test_simul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
